// File: rtl/stereo_pkg.sv
// Shared constants and types for the stereo front end: default frame geometry,
// row-buffer FSM encoding and slot arithmetic.
package stereo_pkg;

    localparam int unsigned DEF_WIN       = 15;
    localparam int unsigned DEF_DATA_SIZE = 8;
    localparam int unsigned DEF_IMG_W     = 640;
    localparam int unsigned DEF_IMG_H     = 480;
    localparam int unsigned ROW_W         = DEF_DATA_SIZE * DEF_IMG_W;
    localparam int unsigned SLOT_W        = $clog2(DEF_WIN + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } wrb_state_t;

    function automatic int unsigned slot_add(input int unsigned base,
                                             input int unsigned offs,
                                             input int unsigned nslots);
        return (base + offs) % nslots;
    endfunction

endpackage

// File: rtl/window_row_buffer_row_rotator.sv
// Combinational reordering of the circular row store into a WIN-row block,
// oldest row in the lowest bits.
module row_rotator
    import stereo_pkg::*;
#(
    parameter int unsigned WIN       = DEF_WIN,
    parameter int unsigned ROW_BITS  = ROW_W,
    parameter int unsigned SLOT_BITS = SLOT_W
) (
    input  logic [ROW_BITS-1:0]     slots [WIN+1],
    input  logic [SLOT_BITS-1:0]    oldest,
    output logic [ROW_BITS*WIN-1:0] block
);

    always_comb begin
        block = '0;
        for (int unsigned r = 0; r < WIN; r++) begin
            block[r*ROW_BITS +: ROW_BITS] =
                slots[SLOT_BITS'(slot_add(32'(oldest), r, WIN + 1))];
        end
    end

endmodule

// File: rtl/window_row_buffer.sv
// Raster pixel stream to WIN-row sliding block buffer feeding the SAD stage.
// Keeps WIN+1 rows so the next row can be written while a block is held.
module window_row_buffer
    import stereo_pkg::*;
#(
    parameter int unsigned WIN       = DEF_WIN,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned IMG_W     = DEF_IMG_W,
    parameter int unsigned IMG_H     = DEF_IMG_H
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_SIZE-1:0]           pix_in,
    input  logic                           pix_sof,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    output logic [DATA_SIZE*IMG_W*WIN-1:0] block_out,
    output logic [$clog2(IMG_H)-1:0]       block_row,
    output logic                           block_valid,
    input  logic                           block_ready,
    output logic                           frame_done
);

    localparam int unsigned ROW_BITS  = DATA_SIZE * IMG_W;
    localparam int unsigned SLOT_BITS = $clog2(WIN + 1);
    localparam int unsigned COL_BITS  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROWI_BITS = $clog2(IMG_H);

    wrb_state_t             state;
    logic [COL_BITS-1:0]    col_cnt, col_eff;
    logic [ROWI_BITS-1:0]   row_cnt, row_eff, pend_row;
    logic [SLOT_BITS-1:0]   wr_slot, slot_eff, slot_inc;
    logic [SLOT_BITS-1:0]   rows_stored, rows_eff;
    logic [SLOT_BITS-1:0]   imm_oldest, pend_oldest, rot_oldest;
    logic                   pending, accept, consume;
    logic                   row_done, block_hit, last_row;
    logic [ROW_BITS-1:0]    slot_mem  [WIN+1];
    logic [ROW_BITS-1:0]    slot_next [WIN+1];
    logic [ROW_BITS*WIN-1:0] rot_block;

    assign pix_ready = !pending && (state != DRAIN);
    assign accept    = pix_valid && pix_ready;
    assign consume   = block_valid && block_ready;

    // A start-of-frame pixel behaves as if all counters were already zero.
    always_comb begin
        col_eff    = pix_sof ? '0 : col_cnt;
        row_eff    = pix_sof ? '0 : row_cnt;
        slot_eff   = pix_sof ? '0 : wr_slot;
        rows_eff   = pix_sof ? '0 : rows_stored;
        row_done   = accept && (col_eff == COL_BITS'(IMG_W - 1));
        block_hit  = rows_eff >= SLOT_BITS'(WIN - 1);
        last_row   = row_eff == ROWI_BITS'(IMG_H - 1);
        slot_inc   = (slot_eff == SLOT_BITS'(WIN)) ? '0 : slot_eff + 1'b1;
        imm_oldest = SLOT_BITS'(slot_add(32'(slot_eff), 32'd2, WIN + 1));
        rot_oldest = pending ? pend_oldest : imm_oldest;
    end

    // The rotator reads the store with this cycle's pixel already merged, so a
    // completing row yields its block on the very next cycle.
    always_comb begin
        for (int unsigned s = 0; s < WIN + 1; s++) begin
            slot_next[s] = slot_mem[s];
        end
        if (accept) begin
            slot_next[slot_eff][col_eff*DATA_SIZE +: DATA_SIZE] = pix_in;
        end
    end

    always_ff @(posedge clk) begin
        slot_mem <= slot_next;
    end

    row_rotator #(
        .WIN       (WIN),
        .ROW_BITS  (ROW_BITS),
        .SLOT_BITS (SLOT_BITS)
    ) u_rotator (
        .slots  (slot_next),
        .oldest (rot_oldest),
        .block  (rot_block)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            col_cnt     <= '0;
            row_cnt     <= '0;
            wr_slot     <= '0;
            rows_stored <= '0;
            pending     <= 1'b0;
            pend_oldest <= '0;
            pend_row    <= '0;
            block_out   <= '0;
            block_row   <= '0;
            block_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                if (row_done) begin
                    col_cnt     <= '0;
                    row_cnt     <= last_row ? '0 : row_eff + 1'b1;
                    wr_slot     <= slot_inc;
                    rows_stored <= (rows_eff == SLOT_BITS'(WIN)) ? rows_eff : rows_eff + 1'b1;
                    state       <= last_row ? DRAIN : (block_hit ? STREAM : FILL);
                end else begin
                    col_cnt     <= col_eff + 1'b1;
                    row_cnt     <= row_eff;
                    wr_slot     <= slot_eff;
                    rows_stored <= rows_eff;
                    if (pix_sof) begin
                        state <= FILL;
                    end
                end
                if (pix_sof) begin
                    block_valid <= 1'b0;
                    pending     <= 1'b0;
                end
            end

            if (row_done && block_hit) begin
                if (!block_valid || consume || pix_sof) begin
                    block_out   <= rot_block;
                    block_row   <= row_eff - ROWI_BITS'(WIN / 2);
                    block_valid <= 1'b1;
                end else begin
                    pending     <= 1'b1;
                    pend_oldest <= imm_oldest;
                    pend_row    <= row_eff - ROWI_BITS'(WIN / 2);
                end
            end else if (consume) begin
                if (pending) begin
                    block_out <= rot_block;
                    block_row <= pend_row;
                    pending   <= 1'b0;
                end else begin
                    block_valid <= 1'b0;
                    if (state == DRAIN) begin
                        frame_done  <= 1'b1;
                        col_cnt     <= '0;
                        row_cnt     <= '0;
                        wr_slot     <= '0;
                        rows_stored <= '0;
                        state       <= FILL;
                    end
                end
            end
        end
    end

endmodule
